product_accumulator: RTL
========================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the run-length count.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, begins a run; sampled only in IDLE.
REQ-005 SHALL have port len, input, CNT_W, number of products in the run; captured with start.
REQ-006 SHALL have port abort, input, 1, synchronous run cancel.
REQ-007 SHALL have port p_in, input, 64, signed two's-complement product from the upstream 32x32 signed multiplier.
REQ-008 SHALL have port p_valid, input, 1, p_in valid.
REQ-009 SHALL have port p_ready, output, 1, block accepts p_in.
REQ-010 SHALL have port acc_out, output, 72, signed full-precision accumulated sum.
REQ-011 SHALL have port acc_sat, output, 64, acc_out clamped to signed 64-bit.
REQ-012 SHALL have port sat, output, 1, acc_sat differs from acc_out.
REQ-013 SHALL have port out_valid, output, 1, result available.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, ACC and DONE, encoded in a registered state variable.
REQ-017 IDLE: start=1 -> clear the accumulator to 0 and load the remaining counter with len; next state ACC if len!=0, DONE if len==0.
REQ-018 ACC: p_ready=1; on p_valid&&p_ready, add sign-extended p_in (72-bit) to the accumulator and decrement the remaining counter; p_valid=0 cycles SHALL change nothing.
REQ-019 ACC: the beat that takes the remaining counter from 1 to 0 SHALL move the state to DONE; out_valid is registered and rises the cycle after that beat (latency 1 clk).
REQ-020 DONE: out_valid=1; acc_out, acc_sat and sat SHALL be held stable; out_ready=1 -> IDLE next cycle.
REQ-021 p_ready SHALL be 0 in IDLE and DONE; p_valid in those states SHALL be ignored with no data lost or counted.
REQ-022 start SHALL be ignored in ACC and DONE, including the cycle DONE is left; a new run needs start in IDLE.
REQ-023 abort=1 in ACC or DONE -> IDLE next cycle, no out_valid pulse, accumulator cleared; abort takes priority over a concurrent data beat or out_ready.
REQ-024 acc_sat = 0x7FFF_FFFF_FFFF_FFFF if acc_out > 2^63-1, 0x8000_0000_0000_0000 if acc_out < -2^63, else acc_out[63:0]; sat=1 only when clamped.
REQ-025 acc_sat and sat are combinational from the accumulator register; no internal wrap at 72 bits SHALL occur for len <= 2^CNT_W-1 given |p_in| <= 2^62.
REQ-026 Outputs acc_out, acc_sat and sat SHALL be valid when out_valid=1 and are don't-care otherwise but SHALL never contain X after reset.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, accumulator 0, remaining counter 0, p_ready=0, out_valid=0, busy=0, acc_out=0, acc_sat=0 and sat=0, regardless of clock.
REQ-028 rst asserted mid-run SHALL discard the partial sum; after release the block SHALL wait for start.

Verification
REQ-029 start with len=3, beats p_in=6, -10, 20 -> out_valid one cycle after the 3rd beat, acc_out=16, acc_sat=16, sat=0.
REQ-030 start with len=0 -> DONE next cycle, out_valid=1, acc_out=0, p_ready never high.
REQ-031 len=4, each p_in=0x4000_0000_0000_0000 -> acc_out=2^64, acc_sat=0x7FFF_FFFF_FFFF_FFFF, sat=1; len=2, each p_in=0x8000_0000_0000_0000 -> acc_sat=0x8000_0000_0000_0000, sat=1.
REQ-032 len=2, p_valid toggling with gaps, then out_ready held low 5 cycles -> only valid beats counted; out_valid and outputs stable, p_ready=0, start pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-033 len=5, rst pulsed after 2 beats -> all outputs 0 asynchronously; new start with len=1, p_in=-7 -> acc_out=-7 (0xFF_FFFF_FFFF_FFFF_FFF9).
REQ-034 len=5, abort together with the 3rd beat -> IDLE next cycle, no out_valid; subsequent run with len=1, p_in=1 -> acc_out=1.

Source files
------------

// File: rtl/product_accumulator.sv
// Run-length accumulator for signed 64-bit products: sums `len` beats into a
// 72-bit register and presents full-precision and 64-bit saturated results.
module product_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic [63:0]      p_in,
    input  logic             p_valid,
    output logic             p_ready,
    output logic [71:0]      acc_out,
    output logic [63:0]      acc_sat,
    output logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [71:0]      acc_q, acc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             out_valid_q, out_valid_d;
    logic [71:0]      p_ext;

    assign p_ext = {{8{p_in[63]}}, p_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
        end
    end

    // out_valid_d mirrors "next state is DONE" so out_valid is a clean flop.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    rem_d = len;
                    if (len == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (abort) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    rem_d   = '0;
                end else if (p_valid) begin
                    acc_d = acc_q + p_ext;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    rem_d   = '0;
                end else if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                rem_d   = '0;
            end
        endcase
    end

    // In range for signed 64-bit exactly when the top nine bits agree.
    always_comb begin
        acc_sat = acc_q[63:0];
        sat     = 1'b0;
        if (!((&acc_q[71:63]) || !(|acc_q[71:63]))) begin
            sat     = 1'b1;
            acc_sat = acc_q[71] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        end
    end

    assign acc_out   = acc_q;
    assign out_valid = out_valid_q;
    assign p_ready   = (state_q == ACC);
    assign busy      = (state_q != IDLE);

endmodule
